// File: rtl/regfile_pc_bypass.sv
// Register file with three combinational read ports, one write port and a PC
// held in the top entry. The PC auto-increments, and same-cycle writes can be forwarded to the read ports.
module regfile_pc_bypass #(
  parameter int WIDTH       = 32,
  parameter int AW          = 4,
  parameter bit BYPASS      = 1'b1,
  parameter int PC_INC      = 4,
  parameter int PC_READ_OFS = 8,
  parameter int RESET_PC    = 0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  input  logic             PCEn,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  input  logic [AW-1:0]    RC,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] PC
);

  localparam int            DEPTH   = 2 ** AW;
  localparam logic [AW-1:0] PC_ADDR = '1;

  logic             w_gpr_wr;
  logic             w_pc_wr;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_view  [DEPTH];
  logic [AW-1:0]    w_raddr [3];
  logic [WIDTH-1:0] w_rdata [3];

  assign w_gpr_wr = WE && (WA != PC_ADDR);
  assign w_pc_wr  = WE && (WA == PC_ADDR);

  // NOTE: each entry is a flop with its own async clear, so Clr zeroes the
  // whole file at once; a RAM macro could not offer that.
  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_gpr
    logic [WIDTH-1:0] r_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or posedge Clr) begin
      if (Clr)                               r_q <= '0;
      else if (w_gpr_wr && (WA == AW'(i)))   r_q <= WD;
    end

    assign w_view[i] = r_q;
  end

  // An explicit branch write takes priority over sequential advance.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)          r_pc <= WIDTH'(RESET_PC);
    else if (w_pc_wr) r_pc <= WD;
    else if (PCEn)    r_pc <= r_pc + WIDTH'(PC_INC);
  end

  assign w_view[DEPTH-1] = r_pc + WIDTH'(PC_READ_OFS);

  assign w_raddr[0] = RA;
  assign w_raddr[1] = RB;
  assign w_raddr[2] = RC;

  // NOTE: every output is assigned before any condition is evaluated, so no
  // path through the block leaves a stale value behind and no latch forms.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_rdata[p] = w_view[w_raddr[p]];
      if (BYPASS && w_gpr_wr && (w_raddr[p] == WA)) w_rdata[p] = WD;
    end
  end

  assign A  = w_rdata[0];
  assign B  = w_rdata[1];
  assign C  = w_rdata[2];
  assign PC = r_pc;

endmodule

// File: tb/tb_regfile_pc_bypass.sv
// Bench for regfile_pc_bypass: directed vectors with literal expectations plus
// an array-based model compared against three instances on every falling edge.
module tb_regfile_pc_bypass;

  logic        clk = 1'b0;
  logic        clr;
  logic        we, pcen;
  logic [3:0]  wa, ra, rb, rc;
  logic [31:0] wd;
  logic [31:0] a0, b0, c0, pc0;
  logic [31:0] a1, b1, c1, pc1;

  logic        we2, pcen2;
  logic [2:0]  wa2, ra2, rb2, rc2;
  logic [15:0] wd2;
  logic [15:0] a2, b2, c2, pc2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_reg  [16];
  logic [31:0] m_pc;
  logic [15:0] m_reg2 [8];
  logic [15:0] m_pc2;

  always #5 clk = ~clk;

  regfile_pc_bypass u_byp (
    .Clk(clk), .Clr(clr), .WE(we), .WA(wa), .WD(wd), .PCEn(pcen),
    .RA(ra), .RB(rb), .RC(rc), .A(a0), .B(b0), .C(c0), .PC(pc0)
  );

  regfile_pc_bypass #(.BYPASS(1'b0)) u_nobyp (
    .Clk(clk), .Clr(clr), .WE(we), .WA(wa), .WD(wd), .PCEn(pcen),
    .RA(ra), .RB(rb), .RC(rc), .A(a1), .B(b1), .C(c1), .PC(pc1)
  );

  regfile_pc_bypass #(.WIDTH(16), .AW(3)) u_small (
    .Clk(clk), .Clr(clr), .WE(we2), .WA(wa2), .WD(wd2), .PCEn(pcen2),
    .RA(ra2), .RB(rb2), .RC(rc2), .A(a2), .B(b2), .C(c2), .PC(pc2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = '0;
    for (int i = 0; i < 8; i++)  m_reg2[i] = '0;
    m_pc  = '0;
    m_pc2 = '0;
  endtask

  function automatic logic [31:0] exp32(input logic [3:0] addr, input bit byp);
    if (addr == 4'd15)                    return m_pc + 32'd8;
    if (byp && we && (wa == addr))        return wd;
    return m_reg[addr];
  endfunction

  function automatic logic [15:0] exp16(input logic [2:0] addr);
    if (addr == 3'd7)                     return m_pc2 + 16'd8;
    if (we2 && (wa2 == addr))             return wd2;
    return m_reg2[addr];
  endfunction

  // Model: architectural effect of each rising edge, written from the rules.
  always @(posedge clk) begin
    if (!clr) begin
      if (we && wa != 4'd15) m_reg[wa] = wd;
      m_pc = (we && wa == 4'd15) ? wd : (pcen ? m_pc + 32'd4 : m_pc);
      if (we2 && wa2 != 3'd7) m_reg2[wa2] = wd2;
      m_pc2 = (we2 && wa2 == 3'd7) ? wd2 : (pcen2 ? m_pc2 + 16'd4 : m_pc2);
    end
  end

  always @(posedge clr) model_reset();

  // Compare process: every falling edge, all ports of all instances.
  always @(negedge clk) begin
    check("byp_A",  a0,  exp32(ra, 1'b1));
    check("byp_B",  b0,  exp32(rb, 1'b1));
    check("byp_C",  c0,  exp32(rc, 1'b1));
    check("byp_PC", pc0, m_pc);
    check("nob_A",  a1,  exp32(ra, 1'b0));
    check("nob_B",  b1,  exp32(rb, 1'b0));
    check("nob_C",  c1,  exp32(rc, 1'b0));
    check("nob_PC", pc1, m_pc);
    check("w16_A",  {16'd0, a2},  {16'd0, exp16(ra2)});
    check("w16_B",  {16'd0, b2},  {16'd0, exp16(rb2)});
    check("w16_C",  {16'd0, c2},  {16'd0, exp16(rc2)});
    check("w16_PC", {16'd0, pc2}, {16'd0, m_pc2});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    clr = 1'b1; we = 1'b0; pcen = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0; rc = '0;
    we2 = 1'b0; pcen2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0; rb2 = '0; rc2 = '0;

    // Reset values, no clock edge yet.
    #2;
    check("rst_A", a0, 32'h0);
    check("rst_B", b0, 32'h0);
    check("rst_C", c0, 32'h0);
    check("rst_PC", pc0, 32'h0);
    ra = 4'd15; ra2 = 3'd7;
    #1;
    check("rst_A_pc", a0, 32'h8);
    check("rst_A16_pc", {16'd0, a2}, 32'h8);
    clr = 1'b0;

    // Write then read on all three ports.
    cyc();
    we = 1'b1; wa = 4'd3; wd = 32'hDEADBEEF;
    cyc();
    we = 1'b0; ra = 4'd3; rb = 4'd3; rc = 4'd3;
    #1;
    check("wr_A", a0, 32'hDEADBEEF);
    check("wr_B", b0, 32'hDEADBEEF);
    check("wr_C", c0, 32'hDEADBEEF);
    ra = 4'd4;
    #1;
    check("wr_A4", a0, 32'h0);

    // Bypass versus no bypass.
    we = 1'b1; wa = 4'd5; wd = 32'h11;
    cyc();
    wd = 32'h22; ra = 4'd5; rb = 4'd5; rc = 4'd5;
    #1;
    check("byp_A_new", a0, 32'h22);
    check("byp_C_new", c0, 32'h22);
    check("nob_A_old", a1, 32'h11);
    check("nob_B_old", b1, 32'h11);
    cyc();
    we = 1'b0;
    #1;
    check("nob_A_after", a1, 32'h22);

    // PC advance, branch write priority, read offset.
    pcen = 1'b1; ra = 4'd15;
    cyc(); cyc(); cyc();
    pcen = 1'b0;
    check("pc_inc3", pc0, 32'hC);
    check("pc_read", a0, 32'h14);
    we = 1'b1; wa = 4'd15; wd = 32'h100; pcen = 1'b1;
    #1;
    check("pc_no_byp", a0, 32'h14);
    cyc();
    we = 1'b0; pcen = 1'b0;
    check("pc_wr_wins", pc0, 32'h100);

    // PC wrap at the top of the range, including the read offset.
    we = 1'b1; wa = 4'd15; wd = 32'hFFFFFFFC;
    cyc();
    we = 1'b0; pcen = 1'b1;
    check("pc_top", pc0, 32'hFFFFFFFC);
    check("pc_read_wrap", a0, 32'h4);
    cyc();
    pcen = 1'b0;
    check("pc_wrap", pc0, 32'h0);

    // Mid-operation asynchronous reset.
    we = 1'b1; wa = 4'd7; wd = 32'h55;
    cyc();
    wa = 4'd15; wd = 32'h40;
    cyc();
    we = 1'b0; ra = 4'd7;
    #1;
    check("pre_rst_r7", a0, 32'h55);
    check("pre_rst_pc", pc0, 32'h40);
    clr = 1'b1;
    #1;
    check("async_r7", a0, 32'h0);
    check("async_pc", pc0, 32'h0);
    ra = 4'd0; rb = 4'd0; rc = 4'd0;
    we = 1'b1; wa = 4'd7; wd = 32'h99; pcen = 1'b1;
    cyc(); cyc();
    we = 1'b0; pcen = 1'b0; ra = 4'd7;
    #1;
    check("rst_hold_r7", a0, 32'h0);
    check("rst_hold_pc", pc0, 32'h0);
    clr = 1'b0;

    // Narrow instance: 16-bit data, entry 7 is the PC.
    cyc();
    we2 = 1'b1; wa2 = 3'd6; wd2 = 16'hBEEF;
    cyc();
    we2 = 1'b0; ra2 = 3'd6;
    #1;
    check("w16_r6", {16'd0, a2}, 32'hBEEF);
    we2 = 1'b1; wa2 = 3'd7; wd2 = 16'hFFFC; ra2 = 3'd7;
    cyc();
    we2 = 1'b0; pcen2 = 1'b1;
    check("w16_pc_top", {16'd0, pc2}, 32'hFFFC);
    check("w16_read_wrap", {16'd0, a2}, 32'h4);
    cyc();
    pcen2 = 1'b0;
    check("w16_pc_wrap", {16'd0, pc2}, 32'h0);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
